// File: rtl/sum_window_avg.sv
// sum_window_avg
//   Groups a stream of unsigned samples into windows of 2^LOG2_N samples.
//   For each window it reports the truncated average, the minimum, the maximum
//   and a wrapping 8-bit window sequence number.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   upstream sample present
//   in_data    sample value (unsigned, WIDTH bits)
//   in_ready   block accepts a sample this cycle
//   out_valid  window result held on out_*
//   out_ready  downstream consumes the result
//   out_avg    floor(window sum / N)
//   out_min    smallest sample of the window
//   out_max    largest sample of the window
//   out_seq    window index, wraps 255 -> 0
module sum_window_avg #(
  parameter int WIDTH  = 8,
  parameter int LOG2_N = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_avg,
  output logic [WIDTH-1:0] out_min,
  output logic [WIDTH-1:0] out_max,
  output logic [7:0]       out_seq
);

  localparam int AW = WIDTH + LOG2_N;  // wide enough for N full-scale samples

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t            state, state_nxt;
  logic [AW-1:0]     acc, acc_sum;
  logic [LOG2_N-1:0] cnt;
  logic [WIDTH-1:0]  run_min, run_max, nxt_min, nxt_max;
  logic [7:0]        seq;
  logic              accept, last;

  // No ready-through path: in_ready only looks at the registered state
  // (gated by rst so nothing is accepted during the reset cycle).
  assign in_ready = (state == ACCUM) && !rst;
  assign accept   = in_valid && in_ready;
  assign last     = &cnt;
  assign acc_sum  = acc + AW'(in_data);

  // First sample of a window loads min/max directly.
  assign nxt_min = (cnt == '0 || in_data < run_min) ? in_data : run_min;
  assign nxt_max = (cnt == '0 || in_data > run_max) ? in_data : run_max;

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (accept && last) state_nxt = HOLD;
      HOLD:    if (out_ready)      state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      run_min   <= '0;
      run_max   <= '0;
      seq       <= '0;
      out_valid <= 1'b0;
      out_avg   <= '0;
      out_min   <= '0;
      out_max   <= '0;
      out_seq   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        if (last) begin
          out_avg   <= WIDTH'(acc_sum >> LOG2_N);
          out_min   <= nxt_min;
          out_max   <= nxt_max;
          out_seq   <= seq;
          seq       <= seq + 8'd1;
          out_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
        end else begin
          acc <= acc_sum;
          cnt <= cnt + 1'b1;
        end
        run_min <= nxt_min;
        run_max <= nxt_max;
      end
      // Result stays registered after the handshake; only valid drops.
      if (state == HOLD && out_ready) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sum_window_avg.sv
module tb_sum_window_avg;
  localparam int WIDTH  = 8;
  localparam int LOG2_N = 3;
  localparam int N      = 1 << LOG2_N;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_avg, out_min, out_max;
  logic [7:0]       out_seq;

  sum_window_avg #(.WIDTH(WIDTH), .LOG2_N(LOG2_N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_avg(out_avg), .out_min(out_min), .out_max(out_max), .out_seq(out_seq)
  );

  always #5 clk = ~clk;

  typedef struct { int avg; int mn; int mx; int seq; } res_t;

  int   errors = 0;
  int   checks = 0;
  int   valid_pct = 100;
  int   rdy_pct = 100;
  res_t expq[$];
  int   win[$];
  int   seq_m = 0;
  bit   rst_prev = 0, prev_hs = 0, prev_done = 0;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a window is the list of accepted samples; results are
  // computed from the list with plain arithmetic.
  function automatic res_t model(input int s[$], input int sq);
    res_t r;
    int sum = 0;
    r.mn = 255; r.mx = 0;
    foreach (s[i]) begin
      sum += s[i];
      if (s[i] < r.mn) r.mn = s[i];
      if (s[i] > r.mx) r.mx = s[i];
    end
    r.avg = sum / N;
    r.seq = sq;
    return r;
  endfunction

  // Random downstream backpressure.
  always @(posedge clk) begin
    #1 out_ready = ($urandom_range(99) < rdy_pct);
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      win.delete();
      expq.delete();
      seq_m = 0;
      prev_hs = 0;
      prev_done = 0;
      if (rst_prev) begin
        check(in_ready == 1'b0, "rst_in_ready", in_ready, 0);
        check(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
        check(out_avg == 0, "rst_out_avg", out_avg, 0);
        check(out_min == 0, "rst_out_min", out_min, 0);
        check(out_max == 0, "rst_out_max", out_max, 0);
        check(out_seq == 0, "rst_out_seq", out_seq, 0);
      end
    end else begin
      check(in_ready == !out_valid, "ready_vs_hold", in_ready, !out_valid);
      if (prev_hs)   check(out_valid == 1'b0, "valid_pulse", out_valid, 0);
      if (prev_done) check(out_valid == 1'b1, "result_latency", out_valid, 1);
      if (out_valid) begin
        if (expq.size() == 0) begin
          check(1'b0, "unexpected_result", out_seq, -1);
        end else begin
          check(out_avg == expq[0].avg, "avg", out_avg, expq[0].avg);
          check(out_min == expq[0].mn,  "min", out_min, expq[0].mn);
          check(out_max == expq[0].mx,  "max", out_max, expq[0].mx);
          check(out_seq == expq[0].seq, "seq", out_seq, expq[0].seq);
        end
      end
      prev_hs   = out_valid && out_ready;
      prev_done = 0;
      if (in_valid && in_ready) begin
        win.push_back(int'(in_data));
        if (win.size() == N) begin
          expq.push_back(model(win, seq_m));
          seq_m = (seq_m + 1) % 256;
          win.delete();
          prev_done = 1;
        end
      end
      if (out_valid && out_ready && expq.size() > 0) void'(expq.pop_front());
    end
    rst_prev = rst;
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Offer one sample (with optional random idle gaps) until it is accepted.
  task automatic send(input int d);
    int t = 0;
    while ($urandom_range(99) >= valid_pct) begin
      in_valid = 1'b0;
      in_data  = WIDTH'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = WIDTH'(d);
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 200) begin
        check(1'b0, "accept_timeout", t, 200);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    do_reset();

    // Ramp 10..80, continuous valid and ready.
    valid_pct = 100; rdy_pct = 100;
    for (int i = 1; i <= N; i++) send(10 * i);
    // All full scale.
    for (int i = 0; i < N; i++) send(255);
    // Truncation.
    send(7);
    for (int i = 1; i < N; i++) send(0);

    // Backpressure: result held while in_valid stays asserted.
    rdy_pct = 0;
    for (int i = 0; i < N; i++) send(i + 1);
    in_valid = 1'b1; in_data = 8'd99;
    repeat (5) @(posedge clk);
    #1 rdy_pct = 100;
    send(99);
    for (int i = 1; i < N; i++) send(1);

    // Reset mid-window.
    for (int i = 0; i < 4; i++) send(200);
    do_reset();
    for (int i = 0; i < N; i++) send(100);

    // 257 windows from a fresh reset so seq wraps 255 -> 0.
    do_reset();
    valid_pct = 70; rdy_pct = 100;
    for (int w = 0; w < 257; w++)
      for (int i = 0; i < N; i++) send(int'($urandom_range(255)));

    // Random backpressure too.
    rdy_pct = 60;
    for (int w = 0; w < 20; w++)
      for (int i = 0; i < N; i++) send(int'($urandom_range(255)));

    rdy_pct = 100;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1 check(expq.size() == 0, "drain", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sum_window_avg.md
# sum_window_avg

Downstream consumer of the 8-bit operand-sum stage in the TinyTapeout top. It accepts a stream of sums over a valid/ready handshake and groups them into fixed windows of 2^LOG2_N samples. For each window it produces the truncated average, minimum, maximum and a wrapping window sequence number. The sequence number identifies the window so the display/readout stage can detect dropped results.

## Interface
- WIDTH, 8, sample width; matches the upstream sum width.
- LOG2_N, 3, log2 of the window length (window N = 8 samples); legal range 1..6.
- clk  in  1  rising-edge clock, the only clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream sample present.
- in_data  in  WIDTH  sample value, unsigned.
- in_ready  out  1  block accepts a sample this cycle.
- out_valid  out  1  window result held on the out_* ports.
- out_ready  in  1  downstream consumes the result.
- out_avg  out  WIDTH  floor(window sum / N).
- out_min  out  WIDTH  smallest sample in the window.
- out_max  out  WIDTH  largest sample in the window.
- out_seq  out  8  window index; increments per completed window, wraps 255→0.

## Operation
- Accept rule: a sample is accepted on a rising edge where in_valid=1 and in_ready=1.
- Internal state:
  - acc: WIDTH+LOG2_N bits, so it can never overflow.
  - cnt: LOG2_N bits.
  - run_min, run_max: WIDTH bits.
  - seq: 8 bits.
  - state: ACCUM or HOLD.
- ACCUM state:
  - in_ready=1.
  - On each accept: acc += in_data; cnt += 1.
  - run_min/run_max update against in_data. The first sample of a window (cnt=0) loads both directly.
- Window completion (accept while cnt = N-1):
  - out_avg ← (acc + in_data) >> LOG2_N, truncating.
  - out_min/out_max ← final values including this sample.
  - out_seq ← seq; then seq += 1.
  - out_valid ← 1; acc, cnt ← 0; state → HOLD.
- HOLD state:
  - in_ready=0; in_valid is ignored and no sample is lost or counted.
  - out_* stay stable while out_valid=1 and out_ready=0.
  - When out_ready=1: out_valid ← 0 and state → ACCUM.
- out_ready while out_valid=0 has no effect.
- Arithmetic: unsigned only, no rounding, no saturation. Min/max use unsigned compare.

## Timing
- Reset values: in_ready=0 during the reset cycle, 1 from the first cycle after rst deasserts.
- All other outputs reset to 0: out_valid, out_avg, out_min, out_max, out_seq. seq, acc, cnt and state (ACCUM) also reset.
- Reset mid-window: the partial window is discarded.
- Reset in HOLD: the pending result is dropped and seq returns to 0.
- Latency: out_valid rises on the edge that accepts sample N; it is visible in the cycle after that accept.
- Throughput:
  - Minimum 1 dead cycle per window: the HOLD cycle where out_ready is sampled.
  - Back-to-back windows therefore take N+1 cycles when out_ready is tied to 1.
- in_ready depends only on registered state, never combinationally on out_ready. There is no ready-through path.
- Handshake on both sides follows AXI-stream-style rules: the producer must hold data stable while valid=1 and ready=0.
- Simultaneous rst and any handshake: rst wins.

## Test plan
- Reset, then 8 samples 10,20,…,80 with in_valid=1 and out_ready=1:
  - out_valid pulses for 1 cycle after the 8th accept.
  - out_avg=45, out_min=10, out_max=80, out_seq=0.
  - in_ready=0 for exactly 1 cycle.
- 8 samples of 255:
  - out_avg=255, min=max=255; no overflow in acc (2040 fits in 11 bits).
- Samples 7,0,0,0,0,0,0,0:
  - out_avg=0 (truncation), min=0, max=7.
- Backpressure: complete a window, then hold out_ready=0 for 5 cycles while in_valid=1:
  - out_* stable and in_ready=0 throughout.
  - After out_ready=1, the next window starts fresh with cnt=0 and no samples were consumed during HOLD.
- Reset after 4 samples, then 8 samples of 100:
  - out_avg=100, out_seq=0; the pre-reset samples have no influence.
- Run 257 windows with out_ready=1:
  - out_seq sequence ends …,254,255,0.
  - Randomised in_valid gaps never change any window's results relative to a reference model.
